// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP multiply-accumulate engine.
// Imported by the engine and its shift-add datapath step.
package dsp_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int MUL_CYCLES_DEF = 32;
  localparam logic [ADDR_W-1:0] DEST_ADDR_DEF = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_WB,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic              acc_en;
  } ops_t;

endpackage

// File: rtl/dsp_shift_add_step.sv
// One combinational shift-add multiply step, modulo 2^DATA_W.
// Carries out of the top bit are dropped on purpose.
module dsp_shift_add_step
  import dsp_pkg::*;
(
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  input  logic [DATA_W-1:0] prod_i,
  output logic [DATA_W-1:0] mcand_o,
  output logic [DATA_W-1:0] mplier_o,
  output logic [DATA_W-1:0] prod_o
);

  always_comb begin
    prod_o   = mplier_i[0] ? prod_i + mcand_i : prod_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/dsp_mac_engine.sv
// Sequential 32x32 shift-add multiply(-accumulate) engine with a
// request/grant writeback to a register-file write port.
module dsp_mac_engine
  import dsp_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEST_ADDR = DEST_ADDR_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              acc_en,
  output logic              wb_req,
  input  logic              wb_gnt,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done
);

  // One extra counter bit: the underflow past zero marks the
  // finalize cycle that follows the last shift-add step.
  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  ops_t              ops_q, ops_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] step_mcand;
  logic [DATA_W-1:0] step_mplier;
  logic [DATA_W-1:0] step_prod;

  dsp_shift_add_step u_step (
    .mcand_i  (ops_q.mcand),
    .mplier_i (ops_q.mplier),
    .prod_i   (prod_q),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier),
    .prod_o   (step_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ops_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    prod_d  = prod_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ops_d = '{mcand: op_a, mplier: op_b,
                    acc: acc_in, acc_en: acc_en};
          prod_d  = '0;
          cnt_d   = CNT_INIT;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q[CNT_W-1]) begin
          res_d   = ops_q.acc_en ? prod_q + ops_q.acc : prod_q;
          state_d = S_WB;
        end else begin
          prod_d       = step_prod;
          ops_d.mcand  = step_mcand;
          ops_d.mplier = step_mplier;
          cnt_d        = cnt_q - CNT_ONE;
        end
      end
      S_WB: begin
        if (wb_gnt) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign wb_req  = (state_q == S_WB);
  assign wb_addr = wb_req ? DEST_ADDR : '0;
  assign wb_data = res_q;

endmodule

// File: tb/tb_dsp_mac_engine.sv
// Self-checking bench for dsp_mac_engine: vector table plus
// hand-written stall, busy-start and reset-abort sequences.
module tb_dsp_mac_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] acc_in;
  logic        acc_en;
  logic        wb_req;
  logic        wb_gnt;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;

  dsp_mac_engine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .acc_in  (acc_in),
    .acc_en  (acc_en),
    .wb_req  (wb_req),
    .wb_gnt  (wb_gnt),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic        en;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: a write completes at the edge after req & gnt seen here.
  always @(negedge clk) begin
    #2;
    if (rst_n && wb_req && wb_gnt) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h expected none", wb_data);
      end else begin
        chk("wb_data", wb_data, exp_q.pop_front());
        chk("wb_addr", 32'(wb_addr), 32'd18);
      end
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] acc, input logic en,
                        input bit now);
    if (!now) @(negedge clk);
    op_a = a;
    op_b = b;
    acc_in = acc;
    acc_en = en;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where wb_req is first seen high.
  task automatic wait_wbreq(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wb_req && k < 60);
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < lim);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input bit now);
    int k;
    launch(v.a, v.b, v.acc, v.en, now);
    exp_q.push_back(v.exp);
    chk("busy_mul", 32'(busy), 32'd1);
    wait_wbreq(k);
    chk("wbreq_latency", 32'(k), 32'd33);
    chk("wbaddr_req", 32'(wb_addr), 32'd18);
    chk("wbdata_req", wb_data, v.exp);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("wbreq_in_done", 32'(wb_req), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int w0;
    vec_t v;
    rst_n = 1'b0;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    acc_in = '0;
    acc_en = 1'b0;
    wb_gnt = 1'b1;

    vecs[0] = '{32'd3, 32'd5, 32'd7, 1'b1, 32'd22};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h1};
    vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'd5, 1'b1, 32'd5};
    vecs[3] = '{32'd6, 32'd7, 32'd99, 1'b0, 32'd42};
    vecs[4] = '{32'h1234_5678, 32'h10, 32'd100, 1'b0, 32'h2345_6780};
    vecs[5] = '{32'h1234, 32'h5678, 32'h11, 1'b1, 32'd103153777};
    vecs[6] = '{32'd7, 32'd0, 32'd123, 1'b1, 32'd123};
    vecs[7] = '{32'h8000_0000, 32'd2, 32'd1, 1'b1, 32'd1};
    vecs[8] = '{32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 32'd0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wbreq", 32'(wb_req), 32'd0);
    chk("rst_wbaddr", 32'(wb_addr), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    rst_n = 1'b1;

    // Back-to-back: each start lands in the cycle right after done.
    for (int i = 0; i < NV; i++) run_vec(vecs[i], i > 0);

    // Stalled grant.
    wb_gnt = 1'b0;
    launch(32'd11, 32'd13, 32'd0, 1'b0, 1'b0);
    exp_q.push_back(32'd143);
    wait_wbreq(k);
    chk("stall_latency", 32'(k), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_wbreq", 32'(wb_req), 32'd1);
      chk("stall_wbaddr", 32'(wb_addr), 32'd18);
      chk("stall_wbdata", wb_data, 32'd143);
      chk("stall_nodone", 32'(done), 32'd0);
    end
    wb_gnt = 1'b1;
    @(negedge clk);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_wbreq_low", 32'(wb_req), 32'd0);
    @(negedge clk);
    chk("stall_idle", 32'(busy), 32'd0);

    // Start while busy is dropped.
    w0 = wr_cnt;
    launch(32'd2, 32'd2, 32'd0, 1'b0, 1'b0);
    exp_q.push_back(32'd4);
    repeat (9) @(negedge clk);
    op_a = 32'd9;
    op_b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_busy", 32'(busy), 32'd1);
    wait_done(60);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_no_queue", 32'(busy), 32'd0);
      chk("busy_no_wbreq", 32'(wb_req), 32'd0);
    end
    chk("busy_one_write", 32'(wr_cnt - w0), 32'd1);
    chk("busy_wbdata", wb_data, 32'd4);

    // Reset abort during MUL.
    w0 = wr_cnt;
    launch(32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wbreq", 32'(wb_req), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wbdata", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    v = '{32'd6, 32'd7, 32'd0, 1'b0, 32'd42};
    run_vec(v, 1'b0);

    repeat (2) @(negedge clk);
    chk("total_writes", 32'(wr_cnt), 32'(NV + 3));
    chk("total_dones", 32'(done_cnt), 32'(NV + 3));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
